// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [1:0]  RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_ERROR
  } hz_state_e;

  // Per-stage hold/clear bundle driven onto the pipeline registers.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_FREEZE = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                       stall_m: 1'b1, stall_w: 1'b1,
                                       flush_d: 1'b0, flush_e: 1'b0};

  localparam hz_ctrl_t CTRL_RESET = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
                                      stall_m: 1'b0, stall_w: 1'b0,
                                      flush_d: 1'b1, flush_e: 1'b1};

  // Unfrozen control: a taken branch squashes both younger stages, a load-use bubbles ID/EX.
  function automatic hz_ctrl_t run_ctrl(input logic lw_stall, input logic pc_src);
    hz_ctrl_t c;
    c.stall_f = lw_stall;
    c.stall_d = lw_stall;
    c.stall_e = 1'b0;
    c.stall_m = 1'b0;
    c.stall_w = 1'b0;
    c.flush_d = pc_src;
    c.flush_e = lw_stall | pc_src;
    return c;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select for one source register; MEM result wins over WB.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel_c = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline stall/flush/forward sequencer with memory-wait freeze and timeout trap.
// Optional HAZARD_PERF_CNT_EN adds stall_cyc, lwstall_cnt and flush_cnt counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cyc,
  output logic [31:0]      lwstall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e        state, state_nx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             mem_err_nx;
  logic             lw_stall, mem_wait, mem_done, freeze;
  logic [1:0]       fwd_a, fwd_b;
  hz_ctrl_t         ctrl;

  forward_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel_c       (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel_c       (fwd_b)
  );

  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign mem_wait = MemReqM & ~MemReadyM;
  // A dropped request while waiting is treated as completion.
  assign mem_done = MemReadyM | ~MemReqM;

  assign freeze = (state == HZ_ERROR) ||
                  ((state == HZ_RUN) && mem_wait) ||
                  ((state == HZ_MEM_WAIT) && !mem_done);

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= HZ_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      mem_err  <= mem_err_nx;
    end
  end

  // Next-state logic; wait_cnt saturates at MEM_TIMEOUT by leaving for ERROR.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    mem_err_nx  = mem_err;
    case (state)
      HZ_RUN: begin
        if (mem_wait) begin
          state_nx    = HZ_MEM_WAIT;
          wait_cnt_nx = CNT_W'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_done) begin
          state_nx    = HZ_RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_nx   = HZ_ERROR;
          mem_err_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end
      HZ_ERROR: begin
        state_nx = HZ_ERROR;
      end
      default: begin
        state_nx    = HZ_RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // Output logic: reset forces the flush pattern, freeze overrides branch and load-use handling.
  always_comb begin
    ctrl      = run_ctrl(lw_stall, PCSrcE);
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (!clr_n) begin
      ctrl      = CTRL_RESET;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign StallW = ctrl.stall_w;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;

`ifdef HAZARD_PERF_CNT_EN
  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cyc   <= '0;
      lwstall_cnt <= '0;
      flush_cnt   <= '0;
    end else if (freeze) begin
      stall_cyc <= stall_cyc + 32'(1);
    end else begin
      if (lw_stall) lwstall_cnt <= lwstall_cnt + 32'(1);
      if (PCSrcE)   flush_cnt   <= flush_cnt + 32'(1);
    end
  end
`endif

endmodule
